// File: rtl/water_level_ctrl.sv
// -----------------------------------------------------------------------------
// water_level_ctrl
//   Water-tank controller. NSENS thermometer-coded level probes are
//   synchronised, debounced and checked for a legal code. The accepted level
//   drives an IDLE/FILL/DRAIN/FAULT state machine with fill hysteresis.
//   The level (or 'E' on a fault) is shown on a 7-segment display.
//
// Ports
//   clk_2        in   1        system clock
//   reset_n      in   1        asynchronous active-low reset
//   sensor       in   NSENS    raw probes, asynchronous, 1 = wet, bit 0 lowest
//   manual_drain in   1        level-sensitive drain request
//   level        out  LW       accepted level (number of wet probes)
//   state        out  2        IDLE=0, FILL=1, DRAIN=2, FAULT=3
//   pump         out  1        fill pump enable (FILL only)
//   drain_valve  out  1        drain valve enable (DRAIN only)
//   alarm        out  1        blinking fault indicator
//   SEG          out  8        bit 7 = dp (mirrors pump), bits 6..0 = gfedcba
// -----------------------------------------------------------------------------
module water_level_ctrl #(
   parameter int NSENS      = 4,
   parameter int STABLE_CYC = 4,
   parameter int LOW_TH     = 1,
   parameter int HIGH_TH    = 3,
   parameter int BLINK_CYC  = 2
) (
   input  logic                         clk_2,
   input  logic                         reset_n,
   input  logic [NSENS-1:0]             sensor,
   input  logic                         manual_drain,
   output logic [$clog2(NSENS+1)-1:0]   level,
   output logic [1:0]                   state,
   output logic                         pump,
   output logic                         drain_valve,
   output logic                         alarm,
   output logic [7:0]                   SEG
);

   localparam int LW = $clog2(NSENS + 1);
   localparam int CW = $clog2(STABLE_CYC + 1);
   localparam int BW = $clog2(BLINK_CYC + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   // A code is a legal thermometer value when it is 0..01..1: adding one
   // to such a code clears every set bit.
   function automatic logic thermo_ok(input logic [NSENS-1:0] code);
      logic [NSENS-1:0] inc;
      inc = code + NSENS'(1);
      return ((code & inc) == '0);
   endfunction

   function automatic logic [LW-1:0] ones_count(input logic [NSENS-1:0] code);
      logic [LW-1:0] n;
      n = '0;
      for (int i = 0; i < NSENS; i++) begin
         n = n + LW'(code[i]);
      end
      return n;
   endfunction

   function automatic logic [6:0] digit_seg(input logic [LW-1:0] lvl);
      logic [2:0] l3;
      logic [6:0] seg;
      l3 = 3'(lvl);
      case (l3)
         3'd0:    seg = 7'h3F;
         3'd1:    seg = 7'h06;
         3'd2:    seg = 7'h5B;
         3'd3:    seg = 7'h4F;
         3'd4:    seg = 7'h66;
         3'd5:    seg = 7'h6D;
         3'd6:    seg = 7'h7D;
         3'd7:    seg = 7'h07;
         default: seg = 7'h79;
      endcase
      return seg;
   endfunction

   // synchroniser and debounce state
   logic [NSENS-1:0] sync1_r;
   logic [NSENS-1:0] sync2_r;
   logic [NSENS-1:0] cand_r;
   logic [CW-1:0]    cnt_r;
   logic [NSENS-1:0] filt_r;
   logic [LW-1:0]    level_r;
   logic             code_valid_r;

   logic             match_s;
   int               run_len_s;
   logic [CW-1:0]    cnt_next_s;
   logic [NSENS-1:0] filt_next_s;
   logic             code_valid_next_s;
   logic [LW-1:0]    level_next_s;

   // FSM and registered outputs
   state_t           state_r;
   state_t           state_next_s;
   logic             pump_r;
   logic             valve_r;
   logic             alarm_r;
   logic [BW-1:0]    blink_r;
   logic [7:0]       seg_r;

   logic             alarm_next_s;
   logic [BW-1:0]    blink_next_s;
   logic [7:0]       seg_next_s;

   // Debounce: cnt_r counts repeats of the candidate after the sample that
   // loaded it, so the current run length is cnt_r+2 on a match and 1 on a
   // change. A value is accepted exactly when its run reaches STABLE_CYC.
   always_comb begin
      match_s = (sync2_r == cand_r);
      if (match_s) begin
         run_len_s = int'(cnt_r) + 32'sd2;
         if (cnt_r < CW'(STABLE_CYC)) begin
            cnt_next_s = cnt_r + CW'(1);
         end else begin
            cnt_next_s = cnt_r;
         end
      end else begin
         run_len_s  = 32'sd1;
         cnt_next_s = '0;
      end

      if (run_len_s == STABLE_CYC) begin
         filt_next_s = sync2_r;
      end else begin
         filt_next_s = filt_r;
      end

      code_valid_next_s = thermo_ok(filt_next_s);
      if (code_valid_next_s) begin
         level_next_s = ones_count(filt_next_s);
      end else begin
         level_next_s = level_r;
      end
   end

   // Synchroniser, candidate tracking and filtered value.
   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         sync1_r <= '0;
         sync2_r <= '0;
         cand_r  <= '0;
         cnt_r   <= '0;
         filt_r  <= '0;
      end else begin
         sync1_r <= sensor;
         sync2_r <= sync1_r;
         cand_r  <= sync2_r;
         cnt_r   <= cnt_next_s;
         filt_r  <= filt_next_s;
      end
   end

   // Level and code validity follow the filtered value on the same edge;
   // the level holds while the code is illegal.
   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         level_r      <= '0;
         code_valid_r <= 1'b1;
      end else begin
         level_r      <= level_next_s;
         code_valid_r <= code_valid_next_s;
      end
   end

   // Next-state logic; an illegal code overrides everything.
   always_comb begin
      state_next_s = state_r;
      if (!code_valid_r) begin
         state_next_s = ST_FAULT;
      end else begin
         case (state_r)
            ST_FAULT: state_next_s = ST_IDLE;
            ST_IDLE: begin
               if (manual_drain && (level_r != '0)) begin
                  state_next_s = ST_DRAIN;
               end else if (level_r <= LW'(LOW_TH)) begin
                  state_next_s = ST_FILL;
               end else begin
                  state_next_s = ST_IDLE;
               end
            end
            ST_FILL: begin
               if (manual_drain) begin
                  state_next_s = ST_DRAIN;
               end else if (level_r >= LW'(HIGH_TH)) begin
                  state_next_s = ST_IDLE;
               end else begin
                  state_next_s = ST_FILL;
               end
            end
            ST_DRAIN: begin
               if (!manual_drain || (level_r == '0)) begin
                  state_next_s = ST_IDLE;
               end else begin
                  state_next_s = ST_DRAIN;
               end
            end
            default: state_next_s = ST_FAULT;
         endcase
      end
   end

   // Alarm blink and display pattern, both computed from the values the
   // state and level registers take on this edge.
   always_comb begin
      alarm_next_s = 1'b0;
      blink_next_s = '0;
      if (state_next_s != ST_FAULT) begin
         alarm_next_s = 1'b0;
         blink_next_s = '0;
      end else if (state_r != ST_FAULT) begin
         alarm_next_s = 1'b1;
         blink_next_s = '0;
      end else if (blink_r == BW'(BLINK_CYC - 1)) begin
         alarm_next_s = ~alarm_r;
         blink_next_s = '0;
      end else begin
         alarm_next_s = alarm_r;
         blink_next_s = blink_r + BW'(1);
      end

      if (state_next_s == ST_FAULT) begin
         seg_next_s = 8'h79;
      end else begin
         seg_next_s = {(state_next_s == ST_FILL), digit_seg(level_next_s)};
      end
   end

   // State register and Moore output registers.
   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         pump_r  <= 1'b0;
         valve_r <= 1'b0;
         alarm_r <= 1'b0;
         blink_r <= '0;
         seg_r   <= 8'h3F;
      end else begin
         state_r <= state_next_s;
         pump_r  <= (state_next_s == ST_FILL);
         valve_r <= (state_next_s == ST_DRAIN);
         alarm_r <= alarm_next_s;
         blink_r <= blink_next_s;
         seg_r   <= seg_next_s;
      end
   end

   assign level       = level_r;
   assign state       = state_r;
   assign pump        = pump_r;
   assign drain_valve = valve_r;
   assign alarm       = alarm_r;
   assign SEG         = seg_r;

endmodule

// File: tb/tb_water_level_ctrl.sv
// -----------------------------------------------------------------------------
// tb_water_level_ctrl
//   Scoreboard bench: the stimulus process drives probes/drain request on the
//   falling edge, runs a behavioural model of the controller for the coming
//   rising edge and queues the expected outputs. A monitor compares them
//   just after each rising edge.
// -----------------------------------------------------------------------------
module tb_water_level_ctrl;

   localparam int NS = 4;
   localparam int SC = 4;
   localparam int LT = 1;
   localparam int HT = 3;
   localparam int BC = 2;

   logic          clk_2 = 1'b0;
   logic          reset_n = 1'b1;
   logic [NS-1:0] sensor = '0;
   logic          manual_drain = 1'b0;
   logic [2:0]    level;
   logic [1:0]    state;
   logic          pump;
   logic          drain_valve;
   logic          alarm;
   logic [7:0]    SEG;

   water_level_ctrl #(
      .NSENS(NS), .STABLE_CYC(SC), .LOW_TH(LT), .HIGH_TH(HT), .BLINK_CYC(BC)
   ) dut (
      .clk_2(clk_2), .reset_n(reset_n), .sensor(sensor),
      .manual_drain(manual_drain), .level(level), .state(state),
      .pump(pump), .drain_valve(drain_valve), .alarm(alarm), .SEG(SEG)
   );

   always #5 clk_2 = ~clk_2;

   typedef struct {
      logic [2:0] level;
      logic [1:0] state;
      logic       pump;
      logic       valve;
      logic       alarm;
      logic [7:0] seg;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [NS-1:0] m_d1, m_d2, m_filt;
   logic [NS-1:0] m_win [SC];
   int            m_level, m_state, m_fault_n;
   bit            m_valid, m_alarm;

   function automatic logic [7:0] seg_of(input int l);
      case (l)
         0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
         4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_reset();
      m_d1 = '0; m_d2 = '0; m_filt = '0;
      for (int i = 0; i < SC; i++) m_win[i] = '0;
      m_level = 0; m_state = 0; m_fault_n = 0; m_valid = 1'b1; m_alarm = 1'b0;
   endtask

   // Expected outputs after one rising edge with inputs s/md applied.
   task automatic model_edge(input logic [NS-1:0] s, input bit md);
      int            ns;
      logic [NS-1:0] samp;
      bit            same;
      exp_t          e;
      // control decision uses the level/validity held before this edge
      if (!m_valid) ns = 3;
      else begin
         case (m_state)
            0: ns = (md && m_level > 0) ? 2 : ((m_level <= LT) ? 1 : 0);
            1: ns = md ? 2 : ((m_level >= HT) ? 0 : 1);
            2: ns = (!md || m_level == 0) ? 0 : 2;
            default: ns = 0;
         endcase
      end
      if (ns == 3) begin
         m_fault_n = (m_state == 3) ? m_fault_n + 1 : 0;
         m_alarm = ((m_fault_n / BC) % 2) == 0;
      end else begin
         m_alarm = 1'b0;
      end
      m_state = ns;
      // probe value reaches the debouncer two edges after it is applied;
      // it is accepted once the last SC samples all agree
      samp = m_d2; m_d2 = m_d1; m_d1 = s;
      for (int i = SC - 1; i > 0; i--) m_win[i] = m_win[i-1];
      m_win[0] = samp;
      same = 1'b1;
      for (int i = 0; i < SC; i++) if (m_win[i] != samp) same = 1'b0;
      if (same) m_filt = samp;
      m_valid = (m_filt == NS'((1 << $countones(m_filt)) - 1));
      if (m_valid) m_level = $countones(m_filt);
      e.level = 3'(m_level);
      e.state = 2'(ns);
      e.pump  = (ns == 1);
      e.valve = (ns == 2);
      e.alarm = m_alarm;
      e.seg   = (ns == 3) ? 8'h79 : (seg_of(m_level) | ((ns == 1) ? 8'h80 : 8'h00));
      exp_q.push_back(e);
   endtask

   task automatic step(input logic [NS-1:0] s, input bit md);
      sensor = s;
      manual_drain = md;
      model_edge(s, md);
      @(negedge clk_2);
   endtask

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_2);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("level", 32'(level), 32'(e.level));
            chk("state", 32'(state), 32'(e.state));
            chk("pump",  32'(pump),  32'(e.pump));
            chk("valve", 32'(drain_valve), 32'(e.valve));
            chk("alarm", 32'(alarm), 32'(e.alarm));
            chk("seg",   32'(SEG),   32'(e.seg));
         end
      end
   end

   // ---------------- stimulus ----------------
   localparam int ND = 16;
   logic [NS-1:0] d_code [ND] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b0000, 4'b0111,
                                  4'b0111, 4'b0011, 4'b0011, 4'b0111, 4'b0011, 4'b0001,
                                  4'b0000, 4'b0000, 4'b0101, 4'b0011};
   int            d_hold [ND] = '{10, 10, 10, 10, 2, 10, 3, 10, 5, 10, 10, 10, 10, 3, 12, 10};
   bit            d_md   [ND] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 1, 0, 0, 0};

   initial begin
      logic [NS-1:0] code;
      bit            md;
      int            hold;

      #1 reset_n = 1'b0;
      #2;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_pump",  32'(pump),  32'd0);
      chk("rst_valve", 32'(drain_valve), 32'd0);
      chk("rst_alarm", 32'(alarm), 32'd0);
      chk("rst_seg",   32'(SEG),   32'h3F);
      repeat (2) @(posedge clk_2);
      @(negedge clk_2);
      reset_n = 1'b1;
      model_reset();

      // directed walk: fill, glitch, drain, fault and recovery
      for (int i = 0; i < ND; i++)
         for (int j = 0; j < d_hold[i]; j++) step(d_code[i], d_md[i]);

      // randomized segments: mostly legal levels, some arbitrary codes
      md = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) < 7) code = NS'((1 << $urandom_range(0, NS)) - 1);
         else code = NS'($urandom_range(0, (1 << NS) - 1));
         if ($urandom_range(0, 5) == 0) md = ~md;
         hold = $urandom_range(1, 10);
         for (int j = 0; j < hold; j++) step(code, md);
      end

      // reach FILL, then pulse reset between clock edges
      for (int i = 0; i < 30 && !(i >= 8 && m_state == 1); i++) step(4'b0000, 1'b0);
      @(posedge clk_2);
      #2 reset_n = 1'b0;
      #1;
      chk("async_state", 32'(state), 32'd0);
      chk("async_pump",  32'(pump),  32'd0);
      chk("async_valve", 32'(drain_valve), 32'd0);
      chk("async_seg",   32'(SEG),   32'h3F);
      @(negedge clk_2);
      reset_n = 1'b1;
      model_reset();
      for (int i = 0; i < 60; i++)
         step(NS'($urandom_range(0, (1 << NS) - 1)) | 4'b0001, $urandom_range(0, 3) == 0);

      @(posedge clk_2);
      #2;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
